cmd_script_seq: RTL and testbench
=================================

# cmd_script_seq

Parametrised host-side command sequencer for DSO_dig system benches and board bring-up. Holds a loadable script of up to DEPTH command/expected-response entries. On start it replays them in order through a UART_comm_mstr-style handshake (send_cmd/cmd_sent, resp_rdy/clr_resp_rdy), checks every response and bounds every wait with a timeout. It replaces hand-written per-command host sequences with one reusable, synthesizable block that reports pass/fail counts and the first failing index.

## Interface
- CMD_W, 24, command width ({opcode, data})
- RESP_W, 8, response width
- DEPTH, 16, script entries (power of two, ≥2)
- TO_W, 20, timeout counter width; timeout fires after 2^TO_W−1 cycles
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ld_valid  in  1  write one script entry this cycle
- ld_cmd  in  CMD_W  entry command
- ld_exp  in  RESP_W  entry expected response
- ld_mask  in  RESP_W  entry compare mask, 1 = bit checked (used only with RESP_MASK_EN)
- ld_full  out  1  script holds DEPTH entries
- clr_script  in  1  empty the script (entry count → 0)
- start  in  1  single-cycle pulse that begins replay from entry 0
- busy  out  1  replay in progress
- done  out  1  single-cycle pulse when replay ends
- cmd  out  CMD_W  command to UART master
- send_cmd  out  1  single-cycle request to UART master
- cmd_sent  in  1  UART master finished transmitting
- resp_rdy  in  1  response byte available
- resp  in  RESP_W  response byte
- clr_resp_rdy  out  1  single-cycle acknowledge of resp_rdy
- pass_cnt  out  $clog2(DEPTH)+1  matching responses in the last replay
- fail_cnt  out  $clog2(DEPTH)+1  mismatching or timed-out entries in the last replay
- first_fail  out  $clog2(DEPTH)  index of the first failing entry (valid when fail_cnt≠0)
- timeout_err  out  1  sticky: at least one entry timed out in the last replay

## Operation
- Script RAM holds DEPTH × (CMD_W+RESP_W[+RESP_W]). A count register n is kept. The write index equals n.
- ld_valid with !busy and !ld_full: store the entry at index n, then n+1. ld_valid while busy or full is dropped silently.
- clr_script with !busy: n←0. clr_script while busy is ignored.
- clr_script and ld_valid in the same cycle: the clear wins and the load is dropped.
- The script is not consumed by replay. Each start replays entries 0..n−1.
- start with busy=1 is ignored.
- start with n=0: go straight to DONE. done pulses and counts are cleared.
- FSM states and transitions:
  - IDLE: on start, clear pass_cnt, fail_cnt, first_fail and timeout_err, set idx←0, go to SEND.
  - SEND: cmd←script[idx].cmd, send_cmd=1 for one cycle, load the timer, go to WAIT_SENT.
  - WAIT_SENT: on cmd_sent, reload the timer and go to WAIT_RESP. On timer expiry go to FAIL_TO.
  - WAIT_RESP: on resp_rdy, capture resp, pulse clr_resp_rdy, go to CHECK. On timer expiry go to FAIL_TO.
  - CHECK: compare the captured response and increment pass_cnt or fail_cnt, then go to NEXT.
  - FAIL_TO: timeout_err←1, fail_cnt+1, then go to NEXT.
  - NEXT: if idx==n−1 go to DONE, else idx+1 and go to SEND.
  - DONE: done=1 for one cycle, then go to IDLE.
- first_fail latches the idx of the first increment of fail_cnt. It is never overwritten later in the same replay.
- resp_rdy seen in WAIT_SENT (early response) is remembered. WAIT_RESP then consumes it on its first cycle.
- Counters saturate at DEPTH. Their width is sized so DEPTH is representable, so saturation never occurs in legal use.

## Timing
- Reset values: all outputs 0, cmd=0, n=0, FSM=IDLE.
- busy=1 in every state except IDLE.
- Best-case entry cost: start→send_cmd takes 1 cycle. cmd_sent→WAIT_RESP takes 1 cycle. resp_rdy→clr_resp_rdy takes 1 cycle. CHECK and NEXT take 1 cycle each.
- For n=1, done pulses 3 cycles after resp_rdy.
- cmd is held stable from SEND until the next SEND.
- The timer counts down from 2^TO_W−1 and expires on reaching 0.
- Reset mid-replay aborts immediately. No done pulse is produced and the script is lost, because n←0.

## Configuration
- RESP_MASK_EN defined: each entry stores ld_mask. Pass means ((resp ^ exp) & mask) == 0.
- RESP_MASK_EN undefined: ld_mask is ignored and not stored. Pass means resp == exp. The RAM is RESP_W bits narrower.

## Structure
- Package cmd_seq_pkg holds:
  - FSM state enum.
  - DSO opcode constants (CFG_GAIN=8'h02, TRIG_LVL=8'h03, TRIG_POS=8'h04, SET_DEC=8'h05, TRIG_CFG=8'h06, RD_TRIG_CFG=8'h07, EEP_WRT=8'h08, EEP_RD=8'h09, DUMP_CH=8'h01).
  - Response constants POS_ACK=8'hA5 and NEG_ACK=8'hEE.
- One sub-module, cmd_seq_timeout: a loadable down-counter with an expiry flag.

## Test plan
- Load 1 entry {02_0010, exp A5}; start; the UART model answers A5 → pass_cnt=1, fail_cnt=0, done pulses once.
- Load 3 entries with the second answered EE against exp A5 → pass_cnt=2, fail_cnt=1, first_fail=1.
- Suppress cmd_sent on entry 0 (TO_W=6) → timeout_err=1, fail_cnt=1, remaining entries still run.
- Load DEPTH entries, then one more ld_valid → ld_full=1, n=DEPTH, extra entry dropped. Replay twice → identical counts.
- RESP_MASK_EN: exp 8'h80, mask 8'h80, response 8'h85 → pass. Without the macro the same response → fail.
- Start with n=0 → done 2 cycles after start, no send_cmd. Assert rst_n low mid-WAIT_RESP → all outputs 0 and no done pulse.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared FSM state, DSO opcodes and response codes
// for the cmd_script_seq host-side command sequencer.
package cmd_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_SENT,
      S_WAIT_RESP,
      S_CHECK,
      S_FAIL_TO,
      S_NEXT,
      S_DONE
   } seq_state_e;

   localparam logic [7:0] DUMP_CH     = 8'h01;
   localparam logic [7:0] CFG_GAIN    = 8'h02;
   localparam logic [7:0] TRIG_LVL    = 8'h03;
   localparam logic [7:0] TRIG_POS    = 8'h04;
   localparam logic [7:0] SET_DEC     = 8'h05;
   localparam logic [7:0] TRIG_CFG    = 8'h06;
   localparam logic [7:0] RD_TRIG_CFG = 8'h07;
   localparam logic [7:0] EEP_WRT     = 8'h08;
   localparam logic [7:0] EEP_RD      = 8'h09;

   localparam logic [7:0] POS_ACK     = 8'hA5;
   localparam logic [7:0] NEG_ACK     = 8'hEE;

endpackage

// File: rtl/cmd_seq_timeout.sv
// cmd_seq_timeout: loadable down-counter; load sets all ones,
// expired_o is high once the count has reached zero.
module cmd_seq_timeout #(
   parameter int W = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= '1;
      end else if (en_i && cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cmd_script_seq.sv
// cmd_script_seq: replays a loaded command/response script over a
// UART master handshake. Define RESP_MASK_EN for masked compares.
module cmd_script_seq
   import cmd_seq_pkg::*;
#(
   parameter int CMD_W  = 24,
   parameter int RESP_W = 8,
   parameter int DEPTH  = 16,
   parameter int TO_W   = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ld_valid,
   input  logic [CMD_W-1:0]           ld_cmd,
   input  logic [RESP_W-1:0]          ld_exp,
   input  logic [RESP_W-1:0]          ld_mask,
   output logic                       ld_full,
   input  logic                       clr_script,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [CMD_W-1:0]           cmd,
   output logic                       send_cmd,
   input  logic                       cmd_sent,
   input  logic                       resp_rdy,
   input  logic [RESP_W-1:0]          resp,
   output logic                       clr_resp_rdy,
   output logic [$clog2(DEPTH):0]     pass_cnt,
   output logic [$clog2(DEPTH):0]     fail_cnt,
   output logic [$clog2(DEPTH)-1:0]   first_fail,
   output logic                       timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   seq_state_e state_q, state_d;

   logic [CMD_W-1:0]  cmd_mem [DEPTH];
   logic [RESP_W-1:0] exp_mem [DEPTH];
`ifdef RESP_MASK_EN
   logic [RESP_W-1:0] mask_mem [DEPTH];
`else
   logic unused_mask;
   assign unused_mask = ^ld_mask;
`endif

   logic [CW-1:0]     n_q;
   logic [AW-1:0]     idx_q;
   logic [AW-1:0]     idx_nx;
   logic [CMD_W-1:0]  cmd_q;
   logic [RESP_W-1:0] resp_q;
   logic              early_q;
   logic [CW-1:0]     pass_q;
   logic [CW-1:0]     fail_q;
   logic [AW-1:0]     ff_q;
   logic              to_q;

   logic ld_we, last, match, pass_inc, fail_inc;
   logic tmr_ld, tmr_en, tmr_exp;

   assign ld_full = (n_q == CW'(DEPTH));
   assign ld_we   = rst_n && ld_valid && !busy
                    && !ld_full && !clr_script;
   assign idx_nx  = idx_q + AW'(1);
   assign last    = (CW'(idx_q) + CW'(1)) == n_q;

`ifdef RESP_MASK_EN
   assign match = ((resp_q ^ exp_mem[idx_q])
                   & mask_mem[idx_q]) == '0;
`else
   assign match = (resp_q == exp_mem[idx_q]);
`endif

   assign pass_inc = (state_q == S_CHECK) && match;
   assign fail_inc = ((state_q == S_CHECK) && !match)
                     || (state_q == S_FAIL_TO);

   cmd_seq_timeout #(.W(TO_W)) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (tmr_ld),
      .en_i      (tmr_en),
      .expired_o (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (start)
               state_d = (n_q == '0) ? S_NEXT : S_SEND;
         S_SEND:      state_d = S_WAIT_SENT;
         S_WAIT_SENT:
            if (cmd_sent)     state_d = S_WAIT_RESP;
            else if (tmr_exp) state_d = S_FAIL_TO;
         S_WAIT_RESP:
            if (resp_rdy || early_q) state_d = S_CHECK;
            else if (tmr_exp)        state_d = S_FAIL_TO;
         S_CHECK:     state_d = S_NEXT;
         S_FAIL_TO:   state_d = S_NEXT;
         S_NEXT:
            state_d = (n_q == '0 || last) ? S_DONE : S_SEND;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_q != S_IDLE);
      send_cmd     = (state_q == S_SEND);
      clr_resp_rdy = (state_q == S_CHECK);
      done         = (state_q == S_DONE);
      tmr_ld       = (state_q == S_SEND)
                     || (state_q == S_WAIT_SENT && cmd_sent);
      tmr_en       = (state_q == S_WAIT_SENT)
                     || (state_q == S_WAIT_RESP);
   end

   always_ff @(posedge clk) begin
      if (ld_we) begin
         cmd_mem[n_q[AW-1:0]] <= ld_cmd;
         exp_mem[n_q[AW-1:0]] <= ld_exp;
`ifdef RESP_MASK_EN
         mask_mem[n_q[AW-1:0]] <= ld_mask;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         n_q     <= '0;
         idx_q   <= '0;
         cmd_q   <= '0;
         resp_q  <= '0;
         early_q <= 1'b0;
         pass_q  <= '0;
         fail_q  <= '0;
         ff_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         if (clr_script && !busy)
            n_q <= '0;
         else if (ld_we)
            n_q <= n_q + CW'(1);

         if (state_q == S_IDLE && start) begin
            pass_q <= '0;
            fail_q <= '0;
            ff_q   <= '0;
            to_q   <= 1'b0;
            idx_q  <= '0;
            if (n_q != '0) cmd_q <= cmd_mem[0];
         end

         if (state_q == S_SEND)
            early_q <= 1'b0;
         else if (state_q == S_WAIT_SENT && resp_rdy)
            early_q <= 1'b1;
         else if (state_q == S_WAIT_RESP
                  && (resp_rdy || early_q)) begin
            resp_q  <= resp;
            early_q <= 1'b0;
         end

         if (pass_inc && pass_q != CW'(DEPTH))
            pass_q <= pass_q + CW'(1);

         // first_fail only latches on the first failure of a replay
         if (fail_inc && fail_q != CW'(DEPTH)) begin
            fail_q <= fail_q + CW'(1);
            if (fail_q == '0) ff_q <= idx_q;
         end

         if (state_q == S_FAIL_TO)
            to_q <= 1'b1;

         if (state_q == S_NEXT && n_q != '0 && !last) begin
            idx_q <= idx_nx;
            cmd_q <= cmd_mem[idx_nx];
         end
      end
   end

   assign cmd         = cmd_q;
   assign pass_cnt    = pass_q;
   assign fail_cnt    = fail_q;
   assign first_fail  = ff_q;
   assign timeout_err = to_q;

endmodule

// File: tb/tb_cmd_script_seq.sv
// tb_cmd_script_seq: scoreboarded bench with a UART master model
// for cmd_script_seq (DEPTH=4, TO_W=6).
module tb_cmd_script_seq;
   import cmd_seq_pkg::*;

   localparam int CMD_W  = 24;
   localparam int RESP_W = 8;
   localparam int DEPTH  = 4;
   localparam int TO_W   = 6;
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;

   localparam int M_NORM  = 0;
   localparam int M_NOSNT = 1;
   localparam int M_EARLY = 2;
   localparam int M_NORSP = 3;

   logic              clk, rst_n;
   logic              ld_valid, ld_full, clr_script, start;
   logic [CMD_W-1:0]  ld_cmd, cmd;
   logic [RESP_W-1:0] ld_exp, ld_mask, resp;
   logic              busy, done, send_cmd, cmd_sent;
   logic              resp_rdy, clr_resp_rdy, timeout_err;
   logic [CW-1:0]     pass_cnt, fail_cnt;
   logic [AW-1:0]     first_fail;

   cmd_script_seq #(
      .CMD_W(CMD_W), .RESP_W(RESP_W),
      .DEPTH(DEPTH), .TO_W(TO_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_valid(ld_valid), .ld_cmd(ld_cmd),
      .ld_exp(ld_exp), .ld_mask(ld_mask),
      .ld_full(ld_full), .clr_script(clr_script),
      .start(start), .busy(busy), .done(done),
      .cmd(cmd), .send_cmd(send_cmd),
      .cmd_sent(cmd_sent), .resp_rdy(resp_rdy),
      .resp(resp), .clr_resp_rdy(clr_resp_rdy),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .first_fail(first_fail), .timeout_err(timeout_err)
   );

   typedef struct {
      int p;
      int f;
      int ff;
      int to;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int sends = 0;
   int send0_cyc = 0;
   int rr_cyc = 0;
   int ent = 0;

   int        mode [8];
   logic [7:0] rv  [8];
   logic [CMD_W-1:0] ecmd [8];

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, act, expv);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // scoreboard consumer: one expectation per done pulse
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("pass_cnt", 32'(pass_cnt), e.p);
            chk("fail_cnt", 32'(fail_cnt), e.f);
            if (e.f != 0)
               chk("first_fail", 32'(first_fail), e.ff);
            chk("timeout_err", 32'(timeout_err), e.to);
         end
      end
   end

   // UART master model
   initial begin
      cmd_sent = 1'b0;
      resp_rdy = 1'b0;
      resp     = '0;
      forever begin
         @(negedge clk);
         if (!busy) ent = 0;
         if (send_cmd && rst_n) begin
            sends++;
            if (ent == 0) send0_cyc = cyc;
            chk("cmd", 32'(cmd), 32'(ecmd[ent]));
            if (mode[ent] == M_EARLY) begin
               resp     = rv[ent];
               resp_rdy = 1'b1;
               rr_cyc   = cyc;
            end
            if (mode[ent] != M_NOSNT) begin
               @(negedge clk);
               cmd_sent = 1'b1;
               @(negedge clk);
               cmd_sent = 1'b0;
               if (mode[ent] == M_NORM) begin
                  resp     = rv[ent];
                  resp_rdy = 1'b1;
                  rr_cyc   = cyc;
               end
               if (mode[ent] != M_NORSP) begin
                  int k;
                  k = 0;
                  while (!clr_resp_rdy && k < 200) begin
                     @(negedge clk);
                     k++;
                  end
                  if (!clr_resp_rdy)
                     chk("clr_resp_rdy_to", 0, 1);
                  resp_rdy = 1'b0;
               end
            end
            ent++;
         end
      end
   end

   task automatic load(input int k, input logic [CMD_W-1:0] c,
                       input logic [7:0] e, input logic [7:0] m,
                       input logic [7:0] r, input int md);
      if (k < 8) begin
         ecmd[k] = c;
         rv[k]   = r;
         mode[k] = md;
      end
      ld_valid = 1'b1;
      ld_cmd   = c;
      ld_exp   = e;
      ld_mask  = m;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic clr();
      clr_script = 1'b1;
      @(negedge clk);
      clr_script = 1'b0;
   endtask

   task automatic push(input int p, input int f,
                       input int ff, input int to);
      exp_t e;
      e.p = p; e.f = f; e.ff = ff; e.to = to;
      sb.push_back(e);
   endtask

   task automatic kick(output int s);
      start = 1'b1;
      s = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int k;
      k = 0;
      while (done_cnt == prev && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt == prev) chk("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   int s, d0, n0;

   initial begin
      rst_n = 1'b0;
      ld_valid = 1'b0; ld_cmd = '0; ld_exp = '0; ld_mask = '0;
      clr_script = 1'b0; start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mode[i] = M_NORM; rv[i] = '0; ecmd[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_outs",
          {busy, done, send_cmd, clr_resp_rdy, ld_full,
           timeout_err, 26'd0}, 0);
      chk("rst_cmd", 32'(cmd), 0);
      chk("rst_cnts", {pass_cnt, fail_cnt, first_fail}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single passing entry, with latency checks
      load(0, {CFG_GAIN, 16'h0010}, POS_ACK, 8'hFF, POS_ACK,
           M_NORM);
      push(1, 0, 0, 0);
      d0 = done_cnt; n0 = sends;
      kick(s);
      wait_done(d0);
      chk("t1_start_to_send", send0_cyc - s, 1);
      chk("t1_resp_to_done", done_cyc - rr_cyc, 3);
      chk("t1_done_once", done_cnt - d0, 1);
      chk("t1_sends", sends - n0, 1);

      // NEG_ACK on the middle entry, early response on the last
      clr();
      load(0, {TRIG_LVL, 16'h0080}, POS_ACK, 8'hFF, POS_ACK, M_NORM);
      load(1, {TRIG_POS, 16'h0100}, POS_ACK, 8'hFF, NEG_ACK, M_NORM);
      load(2, {SET_DEC, 16'h0003}, POS_ACK, 8'hFF, POS_ACK, M_EARLY);
      push(2, 1, 1, 0);
      d0 = done_cnt;
      kick(s);
      wait_done(d0);

      // entry 0 never sees cmd_sent; later entries still run
      clr();
      load(0, {TRIG_CFG, 16'h0011}, POS_ACK, 8'hFF, POS_ACK, M_NOSNT);
      load(1, {RD_TRIG_CFG, 16'h0000}, POS_ACK, 8'hFF, POS_ACK, M_NORM);
      load(2, {EEP_RD, 16'h0004}, POS_ACK, 8'hFF, POS_ACK, M_NORM);
      push(2, 1, 0, 1);
      d0 = done_cnt; n0 = sends;
      kick(s);
      wait_done(d0);
      chk("t3_sends", sends - n0, 3);

      // fill the script and try to overflow it
      clr();
      load(0, {EEP_WRT, 16'h1234}, POS_ACK, 8'hFF, POS_ACK, M_NORM);
      load(1, {DUMP_CH, 16'h0001}, POS_ACK, 8'hFF, POS_ACK, M_NORM);
      load(2, {CFG_GAIN, 16'h0020}, POS_ACK, 8'hFF, NEG_ACK, M_NORM);
      load(3, {TRIG_LVL, 16'h0040}, NEG_ACK, 8'hFF, NEG_ACK, M_NORM);
      chk("t4_full", 32'(ld_full), 1);
      load(9, {SET_DEC, 16'hBEEF}, POS_ACK, 8'hFF, POS_ACK, M_NORM);
      chk("t4_still_full", 32'(ld_full), 1);
      for (int r = 0; r < 2; r++) begin
         push(3, 1, 2, 0);
         d0 = done_cnt; n0 = sends;
         kick(s);
         if (r == 1) begin
            repeat (3) @(negedge clk);
            clr();
            load(9, {SET_DEC, 16'hDEAD}, POS_ACK, 8'hFF,
                 POS_ACK, M_NORM);
         end
         wait_done(d0);
         chk("t4_sends", sends - n0, 4);
         chk("t4_full_after", 32'(ld_full), 1);
      end

      // masked compare: only bit 7 checked when enabled
      clr();
      load(0, {CFG_GAIN, 16'h0001}, 8'h80, 8'h80, 8'h85, M_NORM);
`ifdef RESP_MASK_EN
      push(1, 0, 0, 0);
`else
      push(0, 1, 0, 0);
`endif
      d0 = done_cnt;
      kick(s);
      wait_done(d0);

      // clear beats a same-cycle load, then empty replay
      clr_script = 1'b1;
      ld_valid = 1'b1;
      ld_cmd = {EEP_RD, 16'h0000};
      @(negedge clk);
      clr_script = 1'b0;
      ld_valid = 1'b0;
      chk("t6_not_full", 32'(ld_full), 0);
      push(0, 0, 0, 0);
      d0 = done_cnt; n0 = sends;
      kick(s);
      wait_done(d0);
      chk("t6_start_to_done", done_cyc - s, 2);
      chk("t6_no_send", sends - n0, 0);

      // reset while waiting for a response
      load(0, {TRIG_POS, 16'h0055}, POS_ACK, 8'hFF, POS_ACK, M_NORSP);
      kick(s);
      repeat (6) @(negedge clk);
      chk("t7_busy_pre", 32'(busy), 1);
      d0 = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      chk("t7_rst_outs",
          {busy, done, send_cmd, clr_resp_rdy, ld_full,
           timeout_err, 26'd0}, 0);
      chk("t7_rst_cmd", 32'(cmd), 0);
      chk("t7_rst_cnts", {pass_cnt, fail_cnt, first_fail}, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("t7_no_done", done_cnt - d0, 0);
      push(0, 0, 0, 0);
      d0 = done_cnt; n0 = sends;
      kick(s);
      wait_done(d0);
      chk("t7_script_lost", sends - n0, 0);
      chk("t7_start_to_done", done_cyc - s, 2);

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
